// File: rtl/ssd_capture.sv
// rtl/ssd_capture.sv - seven-segment capture decoder with stability filter
module ssd_capture #(
    parameter int STABLE_CYCLES = 1000,
    parameter bit HEX_EN        = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       Clr,
    input  logic [0:6] SSD,
    output logic [3:0] DIGIT,
    output logic       VALID,
    output logic       BLANK,
    output logic       ERR,
    output logic [7:0] ERR_COUNT
);

    localparam int NW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [0:6]    ALL_OFF = 7'b1111111;
    localparam logic [NW-1:0] N_LAST  = NW'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLED, SETTLING} state_t;

    logic [0:6]    r_sync1, r_sync2, r_cand, r_last;
    logic [NW-1:0] r_n;
    state_t        r_state;
    logic [3:0]    r_digit;
    logic          r_valid, r_blank, r_err;
    logic [7:0]    r_err_count;

    state_t        w_next_state;
    logic          w_change, w_accept, w_new_pattern;
    logic          w_hit;
    logic [3:0]    w_value;

    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            r_sync1 <= ALL_OFF;
            r_sync2 <= ALL_OFF;
        end else begin
            r_sync1 <= SSD;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) r_state <= SETTLED;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_change     = (r_sync2 != r_cand);
        w_next_state = r_state;
        if (w_change)
            w_next_state = SETTLING;
        else if (r_state == SETTLING && r_n == N_LAST)
            w_next_state = SETTLED;
    end

    always_comb begin
        w_accept      = (r_state == SETTLING) && !w_change && (r_n == N_LAST);
        w_new_pattern = w_accept && (r_cand != r_last);
    end

    // Exact-match decode; letters only exist when HEX_EN is set.
    always_comb begin
        w_hit   = 1'b1;
        w_value = 4'd0;
        case (r_cand)
            7'b0000001: w_value = 4'd0;
            7'b1001111: w_value = 4'd1;
            7'b0010010: w_value = 4'd2;
            7'b0000110: w_value = 4'd3;
            7'b1001100: w_value = 4'd4;
            7'b0100100: w_value = 4'd5;
            7'b0100000: w_value = 4'd6;
            7'b0001111: w_value = 4'd7;
            7'b0000000: w_value = 4'd8;
            7'b0001100: w_value = 4'd9;
            7'b0001000: begin w_value = 4'd10; w_hit = HEX_EN; end
            7'b1100000: begin w_value = 4'd11; w_hit = HEX_EN; end
            7'b0110001: begin w_value = 4'd12; w_hit = HEX_EN; end
            7'b1000010: begin w_value = 4'd13; w_hit = HEX_EN; end
            7'b0110000: begin w_value = 4'd14; w_hit = HEX_EN; end
            7'b0111000: begin w_value = 4'd15; w_hit = HEX_EN; end
            default:    w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            r_cand <= ALL_OFF;
            r_n    <= '0;
        end else if (w_change) begin
            r_cand <= r_sync2;
            r_n    <= NW'(1);
        end else if (r_state == SETTLING && r_n != N_LAST) begin
            r_n    <= r_n + 1'b1;
        end
    end

    // Last-accepted pattern includes unrecognized ones so a held bad pattern errors once.
    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            r_last      <= ALL_OFF;
            r_digit     <= 4'd0;
            r_valid     <= 1'b0;
            r_blank     <= 1'b1;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_new_pattern) begin
                r_last <= r_cand;
                if (r_cand == ALL_OFF) begin
                    r_blank <= 1'b1;
                end else if (w_hit) begin
                    r_digit <= w_value;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                    if (r_err_count != 8'd255)
                        r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign DIGIT     = r_digit;
    assign VALID     = r_valid;
    assign BLANK     = r_blank;
    assign ERR       = r_err;
    assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_ssd_capture.sv
// tb/tb_ssd_capture.sv - self-checking bench for ssd_capture
module tb_ssd_capture;

    localparam int SC = 4;

    logic       CLOCK_50 = 1'b0;
    logic       Clr;
    logic [0:6] SSD;
    logic [3:0] digit1, digit0;
    logic       valid1, valid0, blank1, blank0, err1, err0;
    logic [7:0] cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ssd_capture #(.STABLE_CYCLES(SC), .HEX_EN(1'b1)) dut_hex (
        .CLOCK_50(CLOCK_50), .Clr(Clr), .SSD(SSD),
        .DIGIT(digit1), .VALID(valid1), .BLANK(blank1), .ERR(err1), .ERR_COUNT(cnt1)
    );

    ssd_capture #(.STABLE_CYCLES(SC), .HEX_EN(1'b0)) dut_dec (
        .CLOCK_50(CLOCK_50), .Clr(Clr), .SSD(SSD),
        .DIGIT(digit0), .VALID(valid0), .BLANK(blank0), .ERR(err0), .ERR_COUNT(cnt0)
    );

    logic [0:6] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic bit lookup(input logic [0:6] p, input bit hex, output logic [3:0] v);
        lookup = 1'b0;
        v      = 4'd0;
        for (int i = 0; i < 16; i++)
            if ((i < 10 || hex) && codes[i] == p) begin
                lookup = 1'b1;
                v      = 4'(i);
            end
    endfunction

    // Reference: the synchronized stream is the input delayed two edges; a pattern is
    // accepted on the edge where it has been seen SC times in a row since it appeared.
    logic [0:6] m_s1, m_s2, m_sv, m_cur;
    int         m_run;
    logic [0:6] m_l     [2];
    logic [3:0] m_digit [2];
    logic       m_valid [2];
    logic       m_blank [2];
    logic       m_err   [2];
    int         m_cnt   [2];
    logic [3:0] m_v;

    always @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            m_s1 = 7'h7f; m_s2 = 7'h7f; m_cur = 7'h7f; m_run = SC + 1;
            for (int i = 0; i < 2; i++) begin
                m_l[i] = 7'h7f; m_digit[i] = 4'd0; m_valid[i] = 1'b0;
                m_blank[i] = 1'b1; m_err[i] = 1'b0; m_cnt[i] = 0;
            end
        end else begin
            m_sv = m_s2; m_s2 = m_s1; m_s1 = SSD;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0; m_err[i] = 1'b0;
            end
            if (m_sv != m_cur) begin
                m_cur = m_sv;
                m_run = 1;
            end else if (m_run <= SC) begin
                m_run++;
                if (m_run == SC)
                    for (int i = 0; i < 2; i++)
                        if (m_cur != m_l[i]) begin
                            m_l[i] = m_cur;
                            if (m_cur == 7'h7f) m_blank[i] = 1'b1;
                            else if (lookup(m_cur, i == 1, m_v)) begin
                                m_digit[i] = m_v; m_valid[i] = 1'b1; m_blank[i] = 1'b0;
                            end else begin
                                m_err[i] = 1'b1;
                                if (m_cnt[i] < 255) m_cnt[i]++;
                            end
                        end
            end
        end
    end

    task automatic cmp_model(input int i, input logic [3:0] d, input logic v, input logic b,
                             input logic e, input logic [7:0] c);
        checks++;
        if ({d, v, b, e, c} !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], 8'(m_cnt[i])}) begin
            errors++;
            $display("FAIL model_hex%0d t=%0t: got d=%0d v=%0b b=%0b e=%0b c=%0d expected d=%0d v=%0b b=%0b e=%0b c=%0d",
                     i, $time, d, v, b, e, c, m_digit[i], m_valid[i], m_blank[i], m_err[i], m_cnt[i]);
        end
    endtask

    always @(negedge CLOCK_50) begin
        #2;
        cmp_model(1, digit1, valid1, blank1, err1, cnt1);
        cmp_model(0, digit0, valid0, blank0, err0, cnt0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        Clr = 1'b1;
        SSD = 7'h7f;
        @(negedge CLOCK_50);
        Clr = 1'b0;
    endtask

    // Counts posedges (20 max) until VALID on the HEX_EN=1 instance.
    task automatic measure(output int first, output int nvalid, output int nerr);
        first = -1; nvalid = 0; nerr = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge CLOCK_50);
            #1;
            if (valid1) begin
                if (first < 0) first = e;
                nvalid++;
            end
            if (err1) nerr++;
        end
    endtask

    typedef struct {
        logic [0:6] pat;
        int         hold;
        int         digit1;
        int         valid1;
        int         err1;
        int         blank1;
        int         digit0;
        int         err0;
    } vec_t;

    vec_t vecs [9];
    int   first, nv, ne, nv1, ne1, ne0;

    initial begin
        vecs[0] = '{7'b0010010, 10,  2, 1, 0, 0, 2, 0};
        vecs[1] = '{7'b0000110, 10,  3, 1, 0, 0, 3, 0};
        vecs[2] = '{7'b1111111, 10,  3, 0, 0, 1, 3, 0};
        vecs[3] = '{7'b1111110, 20,  3, 0, 1, 1, 3, 1};
        vecs[4] = '{7'b0001000, 10, 10, 1, 0, 0, 3, 1};
        vecs[5] = '{7'b0001000, 10, 10, 0, 0, 0, 3, 0};
        vecs[6] = '{7'b1111000, 10, 10, 0, 1, 0, 3, 1};
        vecs[7] = '{7'b0100000, 10,  6, 1, 0, 0, 6, 0};
        vecs[8] = '{7'b1000010, 10, 13, 1, 0, 0, 6, 1};

        Clr = 1'b1;
        SSD = 7'h7f;
        repeat (2) @(negedge CLOCK_50);
        #1;
        chk("reset_digit", digit1, 0);
        chk("reset_blank", blank1, 1);
        chk("reset_valid_err", {valid1, err1}, 0);
        chk("reset_count", cnt1, 0);
        Clr = 1'b0;

        // First decode latency from reset.
        @(negedge CLOCK_50);
        SSD = 7'b0010010;
        measure(first, nv, ne);
        chk("lat_first_valid_edge", first, 5);
        chk("lat_valid_count", nv, 1);
        chk("lat_no_err", ne, 0);
        chk("lat_digit", digit1, 2);
        chk("lat_blank", blank1, 0);

        // A pattern held too short is never accepted.
        do_reset();
        @(negedge CLOCK_50);
        SSD = 7'b0010010;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        SSD = 7'b0000110;
        measure(first, nv, ne);
        chk("short_first_valid_edge", first, 5);
        chk("short_valid_count", nv, 1);
        chk("short_digit", digit1, 3);

        // Table-driven directed vectors.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge CLOCK_50);
            SSD = vecs[k].pat;
            nv1 = 0; ne1 = 0; ne0 = 0;
            repeat (vecs[k].hold) begin
                @(posedge CLOCK_50);
                #1;
                nv1 += int'(valid1); ne1 += int'(err1); ne0 += int'(err0);
            end
            chk($sformatf("vec%0d_digit_hex", k), digit1, vecs[k].digit1);
            chk($sformatf("vec%0d_valid_hex", k), nv1, vecs[k].valid1);
            chk($sformatf("vec%0d_err_hex", k), ne1, vecs[k].err1);
            chk($sformatf("vec%0d_blank_hex", k), blank1, vecs[k].blank1);
            chk($sformatf("vec%0d_digit_dec", k), digit0, vecs[k].digit0);
            chk($sformatf("vec%0d_err_dec", k), ne0, vecs[k].err0);
        end
        chk("table_errcount_hex", cnt1, 2);
        chk("table_errcount_dec", cnt0, 4);

        // Clear mid-settle discards the candidate.
        @(negedge CLOCK_50);
        SSD = 7'b0100000;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        Clr = 1'b1;
        #1;
        chk("clr_digit", digit1, 0);
        chk("clr_blank", blank1, 1);
        chk("clr_count", cnt1, 0);
        chk("clr_valid_err", {valid1, err1}, 0);
        @(negedge CLOCK_50);
        Clr = 1'b0;
        measure(first, nv, ne);
        chk("clr_first_valid_edge", first, 5);
        chk("clr_valid_count", nv, 1);
        chk("clr_digit_after", digit1, 6);

        // Error counter saturation.
        do_reset();
        ne1 = 0; ne0 = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLOCK_50);
            SSD = k[0] ? 7'b1111110 : 7'b0111111;
            repeat (6) begin
                @(posedge CLOCK_50);
                #1;
                ne1 += int'(err1); ne0 += int'(err0);
            end
        end
        repeat (8) begin
            @(posedge CLOCK_50);
            #1;
            ne1 += int'(err1); ne0 += int'(err0);
        end
        chk("sat_err_strobes_hex", ne1, 300);
        chk("sat_err_strobes_dec", ne0, 300);
        chk("sat_count_hex", cnt1, 255);
        chk("sat_count_dec", cnt0, 255);

        // Random patterns and hold lengths, including glitches, against the model.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(negedge CLOCK_50);
            case ($urandom_range(0, 3))
                0:       SSD = 7'h7f;
                1:       SSD = 7'($urandom);
                default: SSD = codes[$urandom_range(0, 15)];
            endcase
            repeat ($urandom_range(0, 8)) @(negedge CLOCK_50);
        end
        repeat (10) @(negedge CLOCK_50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
